// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// memory, applies EX-stage redirects and hazard stalls, and presents the IF/ID
// pipeline register to decode.
//
// Control semantics: redirect_valid is a single-cycle request that is always
// accepted on the edge it is sampled and outranks stall. stall freezes the PC,
// the in-flight fetch and IF/ID. While stall is high and no redirect is
// pending, imem_en is held low so the memory keeps presenting the word for the
// frozen in-flight fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        misalign_err
);

  logic [31:0] pc_q, pc_d;
  logic        f1_valid_q, f1_valid_d;
  logic [31:0] f1_pc_q, f1_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        misalign_err_q, misalign_err_d;

  // Memory interface: fetch at the PC; reads are suppressed while frozen or in reset.
  always_comb begin
    imem_addr = pc_q;
    imem_en   = (~stall | redirect_valid) & ~reset;
  end

  // Next-state selection: redirect flushes, stall holds, otherwise advance.
  always_comb begin
    pc_d           = pc_q;
    f1_valid_d     = f1_valid_q;
    f1_pc_d        = f1_pc_q;
    id_valid_d     = id_valid_q;
    id_instr_d     = id_instr_q;
    id_pc_d        = id_pc_q;
    id_pc_plus4_d  = id_pc_plus4_q;
    misalign_err_d = redirect_valid & (|redirect_pc[1:0]);

    if (redirect_valid) begin
      // Low address bits are dropped; the in-flight and IF/ID slots are wrong-path.
      pc_d          = {redirect_pc[31:2], 2'b00};
      f1_valid_d    = 1'b0;
      f1_pc_d       = pc_q;
      id_valid_d    = 1'b0;
      id_instr_d    = NOP_INSTR;
      id_pc_d       = f1_pc_q;
      id_pc_plus4_d = f1_pc_q + 32'd4;
    end else if (!stall) begin
      pc_d          = pc_q + 32'd4;
      f1_valid_d    = 1'b1;
      f1_pc_d       = pc_q;
      id_valid_d    = f1_valid_q;
      // Never forward memory data for an empty fetch slot (keeps X out of decode).
      id_instr_d    = f1_valid_q ? imem_rdata : NOP_INSTR;
      id_pc_d       = f1_pc_q;
      id_pc_plus4_d = f1_pc_q + 32'd4;
    end
  end

  // Pipeline state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      f1_valid_q     <= 1'b0;
      f1_pc_q        <= RESET_PC;
      id_valid_q     <= 1'b0;
      id_instr_q     <= NOP_INSTR;
      id_pc_q        <= 32'd0;
      id_pc_plus4_q  <= 32'd0;
      misalign_err_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      f1_valid_q     <= f1_valid_d;
      f1_pc_q        <= f1_pc_d;
      id_valid_q     <= id_valid_d;
      id_instr_q     <= id_instr_d;
      id_pc_q        <= id_pc_d;
      id_pc_plus4_q  <= id_pc_plus4_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // Registered outputs.
  always_comb begin
    id_valid     = id_valid_q;
    id_instr     = id_instr_q;
    id_pc        = id_pc_q;
    id_pc_plus4  = id_pc_plus4_q;
    misalign_err = misalign_err_q;
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: synchronous memory model, directed timing checks and
// an in-order scoreboard of expected fetch addresses.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        misalign_err;

  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .misalign_err   (misalign_err)
  );

  // Clock
  always #5 clk = ~clk;

  // Memory contents: word i holds 32'h1000_0000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  // Synchronous instruction memory: holds its output when not enabled.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // One clock with given inputs; scoreboard pops whenever IF/ID was loaded with a valid instr.
  task automatic tick(input logic st, input logic rv, input logic [31:0] rpc);
    logic [31:0] e;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
    if (!st || rv) begin
      if (id_valid) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_id_pc", id_pc, e);
          chk("sb_id_instr", id_instr, mem_word(e));
          chk("sb_id_pc_plus4", id_pc_plus4, e + 32'd4);
        end
      end else begin
        chk("bubble_instr", id_instr, NOP);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_id_instr"}, id_instr, NOP);
    chk({tag, "_id_pc"}, id_pc, 32'd0);
    chk({tag, "_id_pc_plus4"}, id_pc_plus4, 32'd0);
    chk({tag, "_misalign"}, 32'(misalign_err), 32'd0);
    chk({tag, "_imem_en"}, 32'(imem_en), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // Straight-line fetch from reset
    push_seq(32'h0, 5);
    tick(1'b0, 1'b0, 32'd0);
    chk("first_edge_valid", 32'(id_valid), 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("second_edge_valid", 32'(id_valid), 32'd1);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("pre_stall_pc", id_pc, 32'h8);

    // Stall three cycles with id_pc = 8
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 32'd0);
      chk("stall_imem_en", 32'(imem_en), 32'd0);
      chk("stall_id_pc", id_pc, 32'h8);
      chk("stall_id_instr", id_instr, mem_word(32'h8));
      chk("stall_id_valid", 32'(id_valid), 32'd1);
    end
    tick(1'b0, 1'b0, 32'd0);
    chk("post_stall_pc", id_pc, 32'hC);
    tick(1'b0, 1'b0, 32'd0);
    chk("phase1_drained", 32'(exp_q.size()), 32'd0);

    // Redirect to 0x40: two bubbles then target stream
    push_seq(32'h40, 2);
    tick(1'b0, 1'b1, 32'h40);
    chk("redir_bubble1_valid", 32'(id_valid), 32'd0);
    chk("redir_aligned_no_err", 32'(misalign_err), 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("redir_bubble2_valid", 32'(id_valid), 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("redir_target_pc", id_pc, 32'h40);
    tick(1'b0, 1'b0, 32'd0);
    chk("redir_drained", 32'(exp_q.size()), 32'd0);

    // Redirect together with stall: redirect wins, then stall holds the target
    push_seq(32'h80, 2);
    tick(1'b1, 1'b1, 32'h80);
    chk("rs_valid", 32'(id_valid), 32'd0);
    chk("rs_addr", imem_addr, 32'h80);
    tick(1'b1, 1'b0, 32'd0);
    chk("rs_hold_addr", imem_addr, 32'h80);
    chk("rs_hold_valid", 32'(id_valid), 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("rs_bubble_valid", 32'(id_valid), 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("rs_target_pc", id_pc, 32'h80);
    tick(1'b0, 1'b0, 32'd0);
    chk("rs_drained", 32'(exp_q.size()), 32'd0);

    // Misaligned redirect
    push_seq(32'h100, 1);
    tick(1'b0, 1'b1, 32'h103);
    chk("misalign_pulse", 32'(misalign_err), 32'd1);
    tick(1'b0, 1'b0, 32'd0);
    chk("misalign_clear", 32'(misalign_err), 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("misalign_pc", id_pc, 32'h100);
    chk("misalign_drained", 32'(exp_q.size()), 32'd0);

    // Wrap-around at the top of the address space
    exp_q.push_back(32'hFFFF_FFFC);
    push_seq(32'h0, 2);
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("wrap_top_pc", id_pc, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 32'd0);
    chk("wrap_zero_pc", id_pc, 32'h0);
    tick(1'b0, 1'b0, 32'd0);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Random stalls on a sequential stream
    push_seq(32'h200, 64);
    tick(1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 40; i++) tick(1'($urandom_range(0, 2) == 0), 1'b0, 32'd0);
    exp_q.delete();

    // Reset asserted mid-redirect with stall high, away from a clock edge
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
